// File: rtl/color_input_encoder.sv
// Color input encoder: synchronizes and debounces four game buttons, then
// encodes one debounced press per armed capture window into a 3-bit color.
// A window ends with a press (color_valid), an expiry (timeout) or an abort
// when arm drops. After a press, the FSM waits for a debounced release
// before it returns to idle.
module color_input_encoder #(
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       arm,
    output logic [2:0] color,
    output logic       color_valid,
    output logic       timeout,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] COLOR_NULL = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    sb;
    logic [3:0]    cand_reg, cand_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [2:0]    color_reg, color_next;
    logic          valid_reg, valid_next;
    logic          timeout_reg, timeout_next;
    logic [7:0]    count_reg, count_next;
    logic          busy_reg;
    logic          sb_one_hot;
    logic          dcnt_at_last;

    // Two-flop synchronizer per button; the FSM only ever looks at sb.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            // Metastability filter for one button bit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= btn[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sb[gi] = s2_reg;
        end
    endgenerate

    assign sb_one_hot   = (sb != 4'd0) && ((sb & (sb - 4'd1)) == 4'd0);
    assign dcnt_at_last = ((dcnt_reg + DW'(1)) == D_LAST);

    function automatic logic [2:0] encode(input logic [3:0] onehot);
        logic [2:0] code;
        case (onehot)
            4'b0001: code = 3'd0;
            4'b0010: code = 3'd1;
            4'b0100: code = 3'd2;
            4'b1000: code = 3'd3;
            default: code = COLOR_NULL;
        endcase
        return code;
    endfunction

    // Next-state and result logic; arm-abort beats a press, a press beats expiry.
    always_comb begin
        state_next   = state_reg;
        cand_next    = cand_reg;
        dcnt_next    = dcnt_reg;
        tcnt_next    = tcnt_reg;
        color_next   = color_reg;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        count_next   = count_reg;
        case (state_reg)
            IDLE: begin
                if (arm) begin
                    state_next = WAIT_PRESS;
                    tcnt_next  = '0;
                    dcnt_next  = '0;
                end
            end
            WAIT_PRESS: begin
                if (!arm) begin
                    state_next = IDLE;
                end else if (tcnt_reg == T_LAST) begin
                    state_next   = IDLE;
                    color_next   = COLOR_NULL;
                    timeout_next = 1'b1;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                    if (sb_one_hot) begin
                        cand_next  = sb;
                        dcnt_next  = DW'(1);
                        state_next = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (!arm) begin
                    state_next = IDLE;
                end else if ((sb == cand_reg) && dcnt_at_last) begin
                    state_next = WAIT_RELEASE;
                    color_next = encode(cand_reg);
                    valid_next = 1'b1;
                    count_next = count_reg + 8'd1;
                    dcnt_next  = '0;
                end else if (tcnt_reg == T_LAST) begin
                    state_next   = IDLE;
                    color_next   = COLOR_NULL;
                    timeout_next = 1'b1;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                    if (sb == cand_reg) begin
                        dcnt_next = dcnt_reg + DW'(1);
                    end else begin
                        state_next = WAIT_PRESS;
                    end
                end
            end
            WAIT_RELEASE: begin
                // arm is deliberately ignored so a long press cannot re-trigger.
                if (sb != 4'd0) begin
                    dcnt_next = '0;
                end else if (dcnt_at_last) begin
                    dcnt_next  = '0;
                    state_next = IDLE;
                end else begin
                    dcnt_next = dcnt_reg + DW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cand_reg    <= 4'd0;
            dcnt_reg    <= '0;
            tcnt_reg    <= '0;
            color_reg   <= COLOR_NULL;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            count_reg   <= 8'd0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cand_reg    <= cand_next;
            dcnt_reg    <= dcnt_next;
            tcnt_reg    <= tcnt_next;
            color_reg   <= color_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            count_reg   <= count_next;
            busy_reg    <= (state_next != IDLE);
        end
    end

    assign color       = color_reg;
    assign color_valid = valid_reg;
    assign timeout     = timeout_reg;
    assign busy        = busy_reg;
    assign press_count = count_reg;

endmodule

// File: tb/tb_color_input_encoder.sv
// Bench for color_input_encoder: fixed vector table, hand-built corner
// sequences and randomized traffic, all scored against a behavioural model.
module tb_color_input_encoder;

    localparam int D = 4;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       arm;
    logic [2:0] color;
    logic       color_valid;
    logic       timeout;
    logic       busy;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    color_input_encoder #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .arm        (arm),
        .color      (color),
        .color_valid(color_valid),
        .timeout    (timeout),
        .busy       (busy),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a window is "hunting" for a press or "holding"
    // until the button is released; streak counts in-window edges on which the
    // same single button was seen.
    int m_s1 = 0, m_s2 = 0;
    int m_mode = 0;          // 0 idle, 1 hunting, 2 holding
    int m_age = 0, m_streak = 0, m_cand = 0, m_rel = 0;
    int m_color = 4, m_valid = 0, m_to = 0, m_count = 0;

    function automatic int code_of(input int b);
        for (int i = 0; i < 4; i++) if (b == (1 << i)) return i;
        return 4;
    endfunction

    task automatic model_step(input int r, input int a, input int b);
        int sb;
        if (r != 0) begin
            m_s1 = 0; m_s2 = 0; m_mode = 0; m_age = 0; m_streak = 0;
            m_rel = 0; m_color = 4; m_valid = 0; m_to = 0; m_count = 0;
            return;
        end
        sb = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        m_valid = 0;
        m_to = 0;
        if (m_mode == 0) begin
            if (a != 0) begin
                m_mode = 1; m_age = 0; m_streak = 0;
            end
        end else if (m_mode == 1) begin
            if (a == 0) begin
                m_mode = 0;
            end else if (m_streak > 0 && sb == m_cand && m_streak + 1 == D) begin
                m_color = code_of(m_cand);
                m_valid = 1;
                m_count = (m_count + 1) % 256;
                m_mode = 2;
                m_rel = 0;
            end else if (m_age == T - 1) begin
                m_color = 4; m_to = 1; m_mode = 0;
            end else begin
                m_age++;
                if (m_streak > 0) begin
                    m_streak = (sb == m_cand) ? m_streak + 1 : 0;
                end else if ($countones(sb) == 1) begin
                    m_cand = sb;
                    m_streak = 1;
                end
            end
        end else begin
            m_rel = (sb != 0) ? 0 : m_rel + 1;
            if (m_rel == D) m_mode = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: advance the model with the present inputs, then compare all outputs.
    task automatic cycle();
        int exp_word;
        int act_word;
        model_step(int'(reset), int'(arm), int'(btn));
        @(posedge clk);
        #1;
        exp_word = (m_color << 11) | (m_valid << 10) | (m_to << 9)
                 | ((m_mode != 0 ? 1 : 0) << 8) | m_count;
        act_word = (int'(color) << 11) | (int'(color_valid) << 10)
                 | (int'(timeout) << 9) | (int'(busy) << 8) | int'(press_count);
        check($sformatf("outputs@%0t", $time), act_word, exp_word);
        if (color_valid && timeout) check("valid_and_timeout", 1, 0);
    endtask

    task automatic go_idle();
        reset = 1'b0; arm = 1'b0; btn = 4'd0;
        repeat (8) cycle();
    endtask

    typedef struct {
        logic       rst;
        logic       arm;
        logic [3:0] btn;
        int         n;
        int         color;
        int         valid;
        int         to;
        int         busy;
        int         count;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pulses;
        int last_color;
        int hold;
        reset = 1'b1; arm = 1'b0; btn = 4'd0;

        // reset, blue press with exact latency, release, timeout, abort, reset mid-debounce
        tbl.push_back('{1'b1, 1'b0, 4'b0000,  2, 4, 0, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0100,  1, 4, 0, 0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0100,  4, 4, 0, 0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0100,  1, 2, 1, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0100,  1, 2, 0, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b0, 4'b0000,  5, 2, 0, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b0, 4'b0000,  1, 2, 0, 0, 0, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0011,  1, 2, 0, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0011, 19, 2, 0, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0011,  1, 4, 0, 1, 0, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0011,  1, 4, 0, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b0, 4'b0011,  1, 4, 0, 0, 0, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0010,  4, 4, 0, 0, 1, 1});
        tbl.push_back('{1'b1, 1'b0, 4'b0010,  1, 4, 0, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b0, 4'b0000,  3, 4, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; arm = tbl[i].arm; btn = tbl[i].btn;
            repeat (tbl[i].n) cycle();
            check($sformatf("tbl%0d.color", i), int'(color), tbl[i].color);
            check($sformatf("tbl%0d.valid", i), int'(color_valid), tbl[i].valid);
            check($sformatf("tbl%0d.timeout", i), int'(timeout), tbl[i].to);
            check($sformatf("tbl%0d.busy", i), int'(busy), tbl[i].busy);
            check($sformatf("tbl%0d.count", i), int'(press_count), tbl[i].count);
            $display("row %0d: color=%0d valid=%0d timeout=%0d busy=%0d count=%0d",
                     i, color, color_valid, timeout, busy, press_count);
        end

        // Short red glitch, then a held yellow: one pulse, yellow.
        go_idle();
        pulses = 0; last_color = -1;
        arm = 1'b1; btn = 4'b0001;
        repeat (2) begin cycle(); if (color_valid) begin pulses++; last_color = color; end end
        btn = 4'b0000;
        repeat (2) begin cycle(); if (color_valid) begin pulses++; last_color = color; end end
        btn = 4'b1000;
        repeat (20) begin cycle(); if (color_valid) begin pulses++; last_color = color; end end
        check("glitch_pulses", pulses, 1);
        check("glitch_color", last_color, 3);
        $display("glitch sequence: pulses=%0d color=%0d", pulses, last_color);

        // Long press with arm toggling: one pulse, then a debounced release to idle.
        go_idle();
        pulses = 0;
        arm = 1'b1; btn = 4'b0100;
        for (int i = 0; i < 100; i++) begin
            if (i >= 8 && i % 3 == 0) arm = ~arm;
            cycle();
            if (color_valid) pulses++;
        end
        check("long_press_pulses", pulses, 1);
        arm = 1'b0; btn = 4'b0000;
        repeat (5) cycle();
        check("release_busy_before", int'(busy), 1);
        cycle();
        check("release_busy_after", int'(busy), 0);
        $display("long press: pulses=%0d busy=%0d", pulses, busy);

        // Press acceptance on the very edge the window expires: press wins.
        go_idle();
        arm = 1'b1; btn = 4'b0000;
        repeat (15) cycle();
        btn = 4'b0001;
        repeat (5) cycle();
        check("tie_valid_pre", int'(color_valid), 0);
        cycle();
        check("tie_valid", int'(color_valid), 1);
        check("tie_timeout", int'(timeout), 0);
        check("tie_color", int'(color), 0);
        $display("press/timeout tie: valid=%0d timeout=%0d", color_valid, timeout);

        // 256 accepted presses wrap the counter.
        reset = 1'b1; arm = 1'b0; btn = 4'd0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            arm = 1'b1; btn = 4'(1 << (i % 4));
            repeat (6) cycle();
            check($sformatf("wrap_valid%0d", i), int'(color_valid), 1);
            arm = 1'b0; btn = 4'd0;
            repeat (7) cycle();
            if (i == 254) check("count_255", int'(press_count), 255);
        end
        check("count_wrap", int'(press_count), 0);
        $display("wrap sequence: press_count=%0d", press_count);

        // Randomized traffic against the model.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: btn = 4'(1 << $urandom_range(0, 3));
                    2:    btn = 4'd0;
                    default: btn = 4'($urandom_range(0, 15));
                endcase
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) arm = ~arm;
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        $display("random traffic done: press_count=%0d", press_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
